// File: rtl/mem_router_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_router_pkg: shared types, arbitration modes and default region map. Rev 1.0
// ----------------------------------------------------------------------------
package mem_router_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } slv_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_NUM_SLAVES = 6;
  localparam int DEF_ADDR_W     = 16;

  // Slave 0 sits in the least significant slice: CART, LCDRAM, WRAM, OAM, IOREG, LWRAM.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_LO =
    {16'hFF80, 16'hFF00, 16'hFE00, 16'hC000, 16'h8000, 16'h0000};
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_HI =
    {16'hFFFF, 16'hFF80, 16'hFEA0, 16'hE000, 16'hA000, 16'h8000};

endpackage
`default_nettype wire

// File: rtl/mem_slave_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_slave_port: arbiter plus IDLE/ACCESS/RESP access FSM for one slave. Rev 1.0
// ----------------------------------------------------------------------------
module mem_slave_port
  import mem_router_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = ARB_FIXED
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_MASTERS-1:0]        req_i,
  input  logic [NUM_MASTERS-1:0]        we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic                          s_re_l_o,
  output logic                          s_we_l_o,
  output logic [NUM_MASTERS-1:0]        ack_o,
  output logic                          rd_o
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  slv_state_e              state_q;
  logic [MW-1:0]           grant_q, ptr_q, pick, cand;
  logic                    we_q, re_l_q, we_l_q, ack_q, found;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [NUM_MASTERS-1:0]  own_mask, req_eff;

  assign own_mask = NUM_MASTERS'(1) << grant_q;
  // The master being acked in RESP still holds its strobe; keep it out of the race.
  assign req_eff  = (state_q == S_RESP) ? (req_i & ~own_mask) : req_i;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_MODE == ARB_RR) cand = MW'((int'(ptr_q) + i) % NUM_MASTERS);
      else                    cand = MW'(i);
      if (!found && req_eff[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_l_q  <= 1'b1;
      we_l_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      re_l_q <= 1'b1;
      we_l_q <= 1'b1;
      ack_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (found) begin
            state_q <= S_ACCESS;
            grant_q <= pick;
            ptr_q   <= MW'((int'(pick) + 1) % NUM_MASTERS);
            addr_q  <= m_addr_i[int'(pick)*ADDR_W +: ADDR_W];
            wdata_q <= m_wdata_i[int'(pick)*DATA_W +: DATA_W];
            we_q    <= we_i[pick];
            re_l_q  <= we_i[pick];
            we_l_q  <= ~we_i[pick];
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          state_q <= S_RESP;
          ack_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_re_l_o  = re_l_q;
  assign s_we_l_o  = we_l_q;
  assign ack_o     = ack_q ? own_mask : '0;
  assign rd_o      = ~we_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_router: master decode, error completion and per-slave routing. Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter_router
  import mem_router_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = ARB_FIXED,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_LO = DEF_SLAVE_LO,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_HI = DEF_SLAVE_HI
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET_L,
  input  logic [NUM_MASTERS*ADDR_W-1:0] I_M_ADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] I_M_WDATA,
  input  logic [NUM_MASTERS-1:0]        I_M_RE_L,
  input  logic [NUM_MASTERS-1:0]        I_M_WE_L,
  output logic [NUM_MASTERS-1:0]        O_M_ACK,
  output logic [NUM_MASTERS-1:0]        O_M_ERR,
  output logic [NUM_MASTERS*DATA_W-1:0] O_M_RDATA,
  output logic [NUM_SLAVES*ADDR_W-1:0]  O_S_ADDR,
  output logic [NUM_SLAVES*DATA_W-1:0]  O_S_WDATA,
  output logic [NUM_SLAVES-1:0]         O_S_RE_L,
  output logic [NUM_SLAVES-1:0]         O_S_WE_L,
  input  logic [NUM_SLAVES*DATA_W-1:0]  I_S_RDATA,
  input  logic                          I_ERR_CLR,
  output logic [NUM_MASTERS-1:0]        O_SAME_PORT_ACCESS_ERROR,
  output logic [NUM_MASTERS-1:0]        O_UNMAPPED_ERROR
);

  logic [NUM_MASTERS-1:0] m_re, m_we, active, both, hit_any, unmapped;
  logic [NUM_MASTERS-1:0] err_ack_q, err_ack_d, same_q, same_d, unm_q, unm_d;
  logic [NUM_MASTERS-1:0] ack_any, rd_ack;
  logic [NUM_MASTERS-1:0] slv_req [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] slv_ack [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]  slv_rd;
  logic [DATA_W-1:0]      rd_data [NUM_MASTERS];
  logic [DATA_W-1:0]      rdata_q [NUM_MASTERS];

  assign m_re   = ~I_M_RE_L;
  assign m_we   = ~I_M_WE_L;
  assign active = m_re ^ m_we;
  assign both   = m_re & m_we;

  // First matching region wins, so overlaps resolve to the lowest slave index.
  always_comb begin
    hit_any = '0;
    for (int s = 0; s < NUM_SLAVES; s++) slv_req[s] = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (!hit_any[m] &&
            I_M_ADDR[m*ADDR_W +: ADDR_W] >= SLAVE_LO[s*ADDR_W +: ADDR_W] &&
            I_M_ADDR[m*ADDR_W +: ADDR_W] <  SLAVE_HI[s*ADDR_W +: ADDR_W]) begin
          hit_any[m]    = 1'b1;
          slv_req[s][m] = active[m];
        end
      end
    end
  end

  assign unmapped  = active & ~hit_any;
  // A held error request is acked once, then ignored for the ack cycle itself.
  assign err_ack_d = (both | unmapped) & ~err_ack_q;
  assign same_d    = (same_q & ~{NUM_MASTERS{I_ERR_CLR}}) | (err_ack_d & both);
  assign unm_d     = (unm_q  & ~{NUM_MASTERS{I_ERR_CLR}}) | (err_ack_d & unmapped);

  generate
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
      mem_slave_port #(
        .NUM_MASTERS (NUM_MASTERS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ARB_MODE    (ARB_MODE)
      ) u_port (
        .clk_i     (I_CLK),
        .rst_ni    (I_RESET_L),
        .req_i     (slv_req[s]),
        .we_i      (m_we),
        .m_addr_i  (I_M_ADDR),
        .m_wdata_i (I_M_WDATA),
        .s_addr_o  (O_S_ADDR[s*ADDR_W +: ADDR_W]),
        .s_wdata_o (O_S_WDATA[s*DATA_W +: DATA_W]),
        .s_re_l_o  (O_S_RE_L[s]),
        .s_we_l_o  (O_S_WE_L[s]),
        .ack_o     (slv_ack[s]),
        .rd_o      (slv_rd[s])
      );
    end
  endgenerate

  always_comb begin
    ack_any = '0;
    rd_ack  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) rd_data[m] = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (slv_ack[s][m]) begin
          ack_any[m] = 1'b1;
          if (slv_rd[s]) begin
            rd_ack[m]  = 1'b1;
            rd_data[m] = rd_data[m] | I_S_RDATA[s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      err_ack_q <= '0;
      same_q    <= '0;
      unm_q     <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) rdata_q[m] <= '0;
    end else begin
      err_ack_q <= err_ack_d;
      same_q    <= same_d;
      unm_q     <= unm_d;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (rd_ack[m])         rdata_q[m] <= rd_data[m];
        else if (err_ack_d[m]) rdata_q[m] <= '0;
      end
    end
  end

  always_comb begin
    O_M_RDATA = '0;
    for (int m = 0; m < NUM_MASTERS; m++)
      O_M_RDATA[m*DATA_W +: DATA_W] = rd_ack[m] ? rd_data[m] : rdata_q[m];
  end

  assign O_M_ACK                  = ack_any | err_ack_q;
  assign O_M_ERR                  = err_ack_q;
  assign O_SAME_PORT_ACCESS_ERROR = same_q;
  assign O_UNMAPPED_ERROR         = unm_q;

endmodule
`default_nettype wire
